// File: rtl/cache_arbiter_if.sv
// Cache/memory handshake bundle for cache_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment: both L1 caches plus the memory port.
interface cache_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) ();
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises I-cache and D-cache line transactions onto a single
// cacheline-wide memory port. Only one transaction is outstanding at a time.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN.
//   defined   -> round-robin between simultaneous requesters
//   undefined -> fixed priority, D over I
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t            state;
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              d_req;
  logic              grant_d;

  assign d_req = bus.d_read | bus.d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to D; the reset value means "last grant was I".
  logic last_d;

  // Winner select: with both requesting, the side not granted last wins.
  always_comb begin
    grant_d = 1'b0;
    if (d_req) grant_d = !(bus.i_read && last_d);
  end
`else
  // Winner select: D has fixed priority over I.
  always_comb begin
    grant_d = 1'b0;
    if (d_req) grant_d = 1'b1;
  end
`endif

  // Arbitration FSM. The strobes, address and write data are registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_d  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_read || d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_d <= grant_d;
`endif
            if (grant_d) begin
              state  <= SERVE_D;
              addr_q <= bus.d_address;
              if (bus.d_write) begin
                write_q <= 1'b1;
                wdata_q <= bus.d_wdata;
              end else begin
                read_q  <= 1'b1;
              end
            end else begin
              state  <= SERVE_I;
              addr_q <= bus.i_address;
              read_q <= 1'b1;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = read_q;
  assign bus.pmem_write   = write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Completion is coincident with the memory response. Response data passes straight through.
  assign bus.i_resp  = (state == SERVE_I) && bus.pmem_resp;
  assign bus.d_resp  = (state == SERVE_D) && bus.pmem_resp;
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: directed scenarios followed by randomized traffic.
// Expectations come from a transaction-level model of pending requests and the grant rule.
module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();
  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: which requests the caches currently hold, plus the last winner.
  bit                m_last_d;
  bit                i_pend, d_rd, d_wr;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_data;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, LINE_W'(obs), LINE_W'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_reqs();
    bus.i_read    = i_pend;
    bus.i_address = i_addr;
    bus.d_read    = d_rd;
    bus.d_write   = d_wr;
    bus.d_address = d_addr;
    bus.d_wdata   = d_data;
  endtask

  // Grant rule from the requester's point of view.
  function automatic bit pick_d();
    bit d_pend;
    d_pend = d_rd | d_wr;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    if (i_pend && d_pend) return !m_last_d;
`endif
    return d_pend;
  endfunction

  // Called at a negedge in IDLE with at least one request pending. Runs one whole
  // transaction and returns at the negedge of the following IDLE cycle.
  task automatic serve(input int lat, input logic [LINE_W-1:0] rd);
    bit                wd, ew;
    logic [ADDR_W-1:0] ea;
    wd = pick_d();
    ew = wd && d_wr;
    ea = wd ? d_addr : i_addr;
    m_last_d = wd;
    drive_reqs();
    #1;
    chk1("idle_read", bus.pmem_read, 1'b0);
    chk1("idle_write", bus.pmem_write, 1'b0);
    step();
    for (int k = 1; k <= lat; k++) begin
      bus.pmem_resp = 1'b0;
      if (k == lat) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rd;
      end
      #1;
      chk1("serve_read", bus.pmem_read, !ew);
      chk1("serve_write", bus.pmem_write, ew);
      chk("serve_addr", LINE_W'(bus.pmem_address), LINE_W'(ea));
      if (ew) chk("serve_wdata", bus.pmem_wdata, d_data);
      chk1("i_resp", bus.i_resp, (k == lat) && !wd);
      chk1("d_resp", bus.d_resp, (k == lat) && wd);
      if (k == lat) chk("rdata", wd ? bus.d_rdata : bus.i_rdata, rd);
      step();
    end
    // RELEASE: the winner drops its request; a stray memory response must be ignored.
    if (wd) begin d_rd = 1'b0; d_wr = 1'b0; end
    else i_pend = 1'b0;
    drive_reqs();
    bus.pmem_resp = 1'b1;
    #1;
    chk1("rel_read", bus.pmem_read, 1'b0);
    chk1("rel_write", bus.pmem_write, 1'b0);
    chk1("rel_i_resp", bus.i_resp, 1'b0);
    chk1("rel_d_resp", bus.d_resp, 1'b0);
    step();
    bus.pmem_resp = 1'b0;
  endtask

  initial begin
    int lat, op;
    i_pend = 0; d_rd = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_data = '0;
    m_last_d = 1'b0;
    drive_reqs();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    rst = 1'b0;
    step(); step();
    #1;
    chk1("rst_read", bus.pmem_read, 1'b0);
    chk1("rst_write", bus.pmem_write, 1'b0);
    chk1("rst_i_resp", bus.i_resp, 1'b0);
    chk1("rst_d_resp", bus.d_resp, 1'b0);
    chk("rst_addr", LINE_W'(bus.pmem_address), '0);
    chk("rst_wdata", bus.pmem_wdata, '0);
    rst = 1'b1;
    step();

    // I-cache fill at 0x60 with a 4-cycle memory.
    i_pend = 1; i_addr = 32'h60;
    serve(4, {32{8'hA5}});

    // D-cache write-back.
    d_wr = 1; d_addr = 32'h1000; d_data = {32{8'h3C}};
    serve(2, rand_line());

    // Simultaneous I and D reads, both held: two back-to-back transactions.
    i_pend = 1; i_addr = 32'h2040; d_rd = 1; d_addr = 32'h3080;
    serve(3, rand_line());
    serve(2, rand_line());

    // Repeat the simultaneous request.
    i_pend = 1; i_addr = 32'h40; d_rd = 1; d_addr = 32'h5000;
    serve(1, rand_line());
    serve(1, rand_line());

    // d_read and d_write together are treated as a write.
    d_rd = 1; d_wr = 1; d_addr = 32'h7720; d_data = rand_line();
    serve(2, rand_line());

    // Reset while a write-back is in flight.
    d_wr = 1; d_addr = 32'h9000; d_data = rand_line();
    drive_reqs();
    step();
    #1;
    chk1("pre_rst_write", bus.pmem_write, 1'b1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    m_last_d = 1'b0;
    #1;
    chk1("mid_rst_write", bus.pmem_write, 1'b0);
    chk1("mid_rst_read", bus.pmem_read, 1'b0);
    chk("mid_rst_addr", LINE_W'(bus.pmem_address), '0);
    d_wr = 1'b0;
    drive_reqs();
    bus.pmem_resp = 1'b1;
    #1;
    chk1("stray_d_resp", bus.d_resp, 1'b0);
    chk1("stray_i_resp", bus.i_resp, 1'b0);
    step();
    bus.pmem_resp = 1'b0;
    #1;
    chk1("post_rst_write", bus.pmem_write, 1'b0);
    chk1("post_rst_read", bus.pmem_read, 1'b0);

    // Randomized traffic; a non-granted request stays pending with its address.
    for (int n = 0; n < 60; n++) begin
      if (!i_pend && ($urandom % 2 == 0)) begin
        i_pend = 1; i_addr = $urandom & ~32'h1F;
      end
      if (!(d_rd || d_wr) && ($urandom % 2 == 0)) begin
        op = $urandom % 3;
        d_rd = (op != 1); d_wr = (op != 0);
        d_addr = $urandom & ~32'h1F; d_data = rand_line();
      end
      if (!i_pend && !(d_rd || d_wr)) begin
        i_pend = 1; i_addr = $urandom & ~32'h1F;
      end
      lat = $urandom_range(1, 5);
      serve(lat, rand_line());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
